// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply-divide unit.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Arithmetic ops are the ones with MD_Op[2] clear.
  function automatic logic is_arith(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign conditioning around the unsigned iteration core: magnitudes going in,
// conditional negation of the 64-bit product or 32-bit quotient/remainder coming out.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   abs_a_o,
  output logic [WIDTH-1:0]   abs_b_o,
  output logic               a_neg_o,
  output logic               b_neg_o,
  input  logic               is_mul_i,
  input  logic               neg_lo_i,
  input  logic               neg_hi_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   rem_neg, quo_neg;

  always_comb begin
    a_neg_o = signed_i & a_i[WIDTH-1];
    b_neg_o = signed_i & b_i[WIDTH-1];
    abs_a_o = a_neg_o ? (~a_i + 1'b1) : a_i;
    abs_b_o = b_neg_o ? (~b_i + 1'b1) : b_i;
  end

  always_comb begin
    prod_neg = ~acc_i + 1'b1;
    rem_neg  = ~acc_i[2*WIDTH-1:WIDTH] + 1'b1;
    quo_neg  = ~acc_i[WIDTH-1:0] + 1'b1;
    if (is_mul_i) begin
      {hi_o, lo_o} = neg_lo_i ? prod_neg : acc_i;
    end else begin
      hi_o = neg_hi_i ? rem_neg : acc_i[2*WIDTH-1:WIDTH];
      lo_o = neg_lo_i ? quo_neg : acc_i[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32 one-bit iterations on magnitudes,
// then a sign-fix cycle that writes HI/LO and pulses Done.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_N,
  input  logic             Start,
  input  logic [2:0]       MD_Op,
  input  logic [WIDTH-1:0] In_1,
  input  logic [WIDTH-1:0] In_2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q, raw_a_q, hi_q, lo_q;
  logic               is_mul_q, neg_lo_q, neg_hi_q, div0_q, done_q;

  logic [WIDTH-1:0]   abs_a, abs_b, fix_hi, fix_lo;
  logic               a_neg, b_neg;
  logic               start_arith;
  logic [WIDTH:0]     add_sum, trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_i (~MD_Op[0]),
    .a_i      (In_1),
    .b_i      (In_2),
    .abs_a_o  (abs_a),
    .abs_b_o  (abs_b),
    .a_neg_o  (a_neg),
    .b_neg_o  (b_neg),
    .is_mul_i (is_mul_q),
    .neg_lo_i (neg_lo_q),
    .neg_hi_i (neg_hi_q),
    .acc_i    (acc_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  assign start_arith = Start && (state_q == IDLE) && is_arith(MD_Op);

  // Multiply: acc = {partial, multiplier}; add on LSB, shift right.
  // Divide:   acc = {remainder, dividend->quotient}; trial-subtract, shift left.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {add_sum, acc_q[WIDTH-1:1]};
    trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
    div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge Clk) begin
    if (!Rst_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_arith) state_d = CALC;
      CALC:    if (count_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q != IDLE);
  end

  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      raw_a_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_mul_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_arith) begin
            count_q  <= '0;
            is_mul_q <= !MD_Op[1];
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            div0_q   <= MD_Op[1] && (In_2 == '0);
            raw_a_q  <= In_1;
            acc_q    <= MD_Op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            opb_q    <= MD_Op[1] ? abs_b : abs_a;
          end else if (Start && MD_Op == MD_MTHI) begin
            hi_q <= In_1;
          end else if (Start && MD_Op == MD_MTLO) begin
            lo_q <= In_1;
          end
        end
        CALC: begin
          acc_q   <= is_mul_q ? mul_next : div_next;
          count_q <= count_q + 1'b1;
        end
        FIX: begin
          hi_q    <= div0_q ? raw_a_q : fix_hi;
          lo_q    <= div0_q ? DIV0_LO : fix_lo;
          done_q  <= 1'b1;
          count_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, sign rules, divide-by-zero,
// move-to ops, Start-while-Busy and mid-op reset.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_N, Start;
  logic [2:0]  MD_Op;
  logic [31:0] In_1, In_2;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Start(Start), .MD_Op(MD_Op),
    .In_1(In_1), .In_2(In_2), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  // Presents one request for exactly one edge, returns #1 after that edge.
  task automatic do_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MD_Op = op; In_1 = a; In_2 = b;
    @(posedge Clk); #1;
    Start = 1'b0; MD_Op = 3'b110; In_1 = 32'hA5A5_A5A5; In_2 = 32'h0;
  endtask

  task automatic test_reset();
    Rst_N = 1'b0; Start = 1'b0; MD_Op = 3'b110; In_1 = '0; In_2 = '0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    n_checks++; if (HI !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", HI); end
    n_checks++; if (LO !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", LO); end
    Rst_N = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_arith(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    do_start(op, a, b);
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_start got %b want 1", name, Busy); end
    repeat (32) @(posedge Clk);
    #1;
    n_checks++; if (Busy !== 1'b1 || Done !== 1'b0)
      begin n_fail++; $display("FAIL %s edge32 busy/done got %b/%b want 1/0", name, Busy, Done); end
    n_checks++; if (HI !== model_hi || LO !== model_lo)
      begin n_fail++; $display("FAIL %s hold got %h/%h want %h/%h", name, HI, LO, model_hi, model_lo); end
    @(posedge Clk); #1;
    n_checks++; if (Done !== 1'b1 || Busy !== 1'b0)
      begin n_fail++; $display("FAIL %s edge33 done/busy got %b/%b want 1/0", name, Done, Busy); end
    n_checks++; if (HI !== ehi) begin n_fail++; $display("FAIL %s hi got %h want %h", name, HI, ehi); end
    n_checks++; if (LO !== elo) begin n_fail++; $display("FAIL %s lo got %h want %h", name, LO, elo); end
    model_hi = ehi; model_lo = elo;
    @(posedge Clk); #1;
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse got %b want 0", name, Done); end
  endtask

  task automatic test_mult();
    test_arith("mult_neg",  MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    test_arith("multu",     MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
    test_arith("mult_min2", MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
  endtask

  task automatic test_div();
    test_arith("div_neg", MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_arith("divu",    MD_DIVU, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
    test_arith("div_nd",  MD_DIV,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
  endtask

  task automatic test_div_edge();
    test_arith("div0",     MD_DIV,  32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    test_arith("div0_neg", MD_DIV,  32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    test_arith("divu0",    MD_DIVU, 32'h8000_0005, 32'h0, 32'h8000_0005, 32'hFFFF_FFFF);
    test_arith("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
  endtask

  task automatic test_move();
    do_start(MD_MTHI, 32'hDEAD_BEEF, 32'h0);
    n_checks++; if (HI !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mthi got %h want deadbeef", HI); end
    n_checks++; if (LO !== model_lo) begin n_fail++; $display("FAIL mthi_lo got %h want %h", LO, model_lo); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %b want 0", Busy); end
    model_hi = 32'hDEAD_BEEF;
    do_start(MD_MTLO, 32'h1234_5678, 32'h0);
    n_checks++; if (LO !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo got %h want 12345678", LO); end
    n_checks++; if (HI !== model_hi) begin n_fail++; $display("FAIL mtlo_hi got %h want %h", HI, model_hi); end
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b0)
      begin n_fail++; $display("FAIL mtlo_busy/done got %b/%b want 0/0", Busy, Done); end
    model_lo = 32'h1234_5678;
    do_start(3'b111, 32'h5555_5555, 32'h3);
    @(posedge Clk); #1;
    n_checks++; if (HI !== model_hi || LO !== model_lo || Busy !== 1'b0)
      begin n_fail++; $display("FAIL noop got %h/%h busy %b want %h/%h busy 0", HI, LO, Busy, model_hi, model_lo); end
  endtask

  task automatic test_busy_ignore();
    int busy_seen;
    do_start(MD_MULT, 32'd3, 32'd5);
    repeat (4) @(posedge Clk);
    #1;
    Start = 1'b1; MD_Op = MD_DIV; In_1 = 32'd100; In_2 = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0; MD_Op = 3'b110;
    repeat (28) @(posedge Clk);
    #1;
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL busy_ign_done got %b want 1", Done); end
    n_checks++; if (HI !== 32'h0 || LO !== 32'd15)
      begin n_fail++; $display("FAIL busy_ign_result got %h/%h want 0/f", HI, LO); end
    model_hi = 32'h0; model_lo = 32'd15;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Busy !== 1'b0 || Done !== 1'b0) busy_seen++;
    end
    n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL busy_ign_queued got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_reset_mid();
    int stray;
    do_start(MD_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge Clk);
    #1;
    Rst_N = 1'b0;
    @(posedge Clk); #1;
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid busy/done got %b/%b want 0/0", Busy, Done); end
    n_checks++; if (HI !== 32'h0 || LO !== 32'h0)
      begin n_fail++; $display("FAIL rst_mid hilo got %h/%h want 0/0", HI, LO); end
    Rst_N = 1'b1;
    model_hi = '0; model_lo = '0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done !== 1'b0 || Busy !== 1'b0 || HI !== 32'h0) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL rst_mid_stray got %0d bad cycles want 0", stray); end
    test_arith("mult_after_rst", MD_MULT, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_move();
    test_busy_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply-divide unit for the MIPS core. It sits beside the ALU in the execute stage and is fed by the same rs/rt operand path. It executes mult/multu/div/divu over 33 cycles and mthi/mtlo in one cycle. Its HI and LO registers feed back into the ALU operand/writeback muxes for mfhi/mflo, and its Busy output stalls the PC while a result is pending.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- Clk  input  1  rising-edge clock
- Rst_N  input  1  synchronous, active-low reset
- Start  input  1  request strobe; sampled only in IDLE
- MD_Op  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
- In_1  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- In_2  input  32  rt operand (divisor / multiplier)
- Busy  output  1  high while an arithmetic op is in flight
- Done  output  1  one-cycle pulse when HI/LO are updated by an arithmetic op
- HI  output  32  HI register (product[63:32] or remainder)
- LO  output  32  LO register (product[31:0] or quotient)

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - Start with mult/multu/div/divu: capture operands, go to CALC, set count = 0.
    - Signed ops capture magnitudes plus result-sign flags.
    - Unsigned ops capture operands raw.
  - Start with mthi: HI ← In_1 at that edge; state stays IDLE; Busy stays low; no Done pulse.
  - Start with mtlo: same, writing LO.
  - Start with 11x: ignored.
- **CALC**
  - One iteration per cycle; go to FIX after the 32nd iteration (count == 31).
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract into a 32-bit remainder and quotient.
- **FIX**
  - Apply sign correction, write HI/LO, pulse Done, return to IDLE.
- **Sign rules**
  - Signed multiply: negate the 64-bit product when the operand signs differ.
  - Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- **Divide by zero**
  - Full latency is kept.
  - HI = In_1 as captured.
  - LO = 0xFFFFFFFF, for both div and divu.
- Start while Busy: ignored; the operands and op in flight are unaffected.
- HI/LO hold their values between updates. During CALC they keep their previous contents; they are never partially written.
- Reset: HI = 0, LO = 0, Busy = 0, Done = 0, state = IDLE, count = 0.
  - Reset asserted mid-operation aborts the op; HI/LO go to 0.

## Timing
- Start accepted at edge N (IDLE, arithmetic op):
  - Busy = 1 from edge N through edge N+33.
  - CALC iterations occur at edges N+1..N+32.
  - FIX writes HI/LO at edge N+33.
  - Done = 1 during the cycle following edge N+33.
  - Busy = 0 from edge N+33.
- Total latency is 33 cycles, fixed and independent of operand values (including divide by zero).
- A new Start may be accepted at edge N+34. That is the first edge at which Busy is low at the preceding sample.
- mthi/mtlo: visible on HI/LO the cycle after edge N; zero stall.
- The core must stall mfhi/mflo, mthi/mtlo, and any new mult/div while Busy = 1.

## Structure
- Package mdu_pkg:
  - MD_Op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - State enum (IDLE, CALC, FIX).
  - DIV0_LO constant = 32'hFFFFFFFF.
- One sub-module, mdu_sign_fix: combinational abs-value pre-conditioning and 64/32-bit conditional negation in post-conditioning. The FSM, counter, and iteration datapath stay in mult_div_unit.

## Test plan
- Signed and unsigned multiply:
  - mult In_1 = 0xFFFFFFFF, In_2 = 0x00000002 → after 33 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFFE, with a one-cycle Done.
  - multu with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- Signed and unsigned divide:
  - div In_1 = 0xFFFFFFF9 (−7), In_2 = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu In_1 = 100, In_2 = 7 → LO = 0x0000000E, HI = 0x00000002.
- Edge-case divides:
  - div In_1 = 0x00001234, In_2 = 0 → HI = 0x00001234, LO = 0xFFFFFFFF, still 33 cycles.
  - div In_1 = 0x80000000, In_2 = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Move-to and busy interaction:
  - mthi 0xDEADBEEF → HI updates next cycle, Busy never rises.
  - Start mult, then Start div at cycle 5 → div ignored; mult result correct at cycle 33.
- Reset mid-operation: Rst_N low at cycle 10 of a divu → next cycle Busy = 0, HI = LO = 0, no Done; a fresh mult then completes normally.
